fifo_push_arb: RTL

FIFO_PUSH_ARB -- requirements
Module: fifo_push_arb

---
 rtl/fifo_push_arb_pkg.sv | 12 +
 rtl/fifo_push_arb_rr_pick.sv | 28 ++
 rtl/fifo_push_arb.sv | 118 +++++++++++
 3 files changed

// File: rtl/fifo_push_arb_pkg.sv
// Shared types and constants for the FIFO push arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int unsigned BEAT_W  = 8;
  localparam int unsigned STALL_W = 16;

endpackage

// File: rtl/fifo_push_arb_rr_pick.sv
// Round-robin picker: first set bit of i_valid at or after i_start, wrapping.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = 2
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [IW-1:0]   i_start,
  output logic            o_found,
  output logic [IW-1:0]   o_index
);

  int unsigned w_cand;

  always_comb begin
    o_found = 1'b0;
    o_index = '0;
    w_cand  = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_cand = 32'(i_start) + k;
      if (w_cand >= NREQ) w_cand = w_cand - NREQ;
      if (!o_found && i_valid[w_cand[IW-1:0]]) begin
        o_found = 1'b1;
        o_index = w_cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_push_arb.sv
// Round-robin arbiter granting one requester at a time bursts into a shared FIFO.
// Optional stall counter output enabled by defining FIFO_PUSH_ARB_STATS_EN.
module fifo_push_arb
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_last,
  input  logic [NREQ*WIDTH-1:0]    req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     fifo_full,
  output logic                     push,
  output logic [WIDTH-1:0]         data_in,
  output logic [$clog2(NREQ)-1:0]  grant_id,
`ifdef FIFO_PUSH_ARB_STATS_EN
  output logic                     busy,
  output logic [STALL_W-1:0]       stall_cnt
`else
  output logic                     busy
`endif
);

  localparam int unsigned IW = $clog2(NREQ);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic [IW-1:0]     r_grant_id;
  logic [IW-1:0]     r_rr_ptr;
  logic [IW-1:0]     w_pick_idx;
  logic [IW-1:0]     w_grant_inc;
  logic [BEAT_W-1:0] r_beat_cnt;
  logic [BEAT_W-1:0] w_beat_inc;
  logic              w_found;
  logic              w_busy;
  logic              w_own_valid;
  logic              w_own_last;
  logic              w_push;
  logic              w_done;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .i_valid (req_valid),
    .i_start (r_rr_ptr),
    .o_found (w_found),
    .o_index (w_pick_idx)
  );

  // Gating with rst keeps every handshake output quiet in the reset cycle itself.
  assign w_busy      = (r_state == GRANT) && !rst;
  assign w_own_valid = req_valid[r_grant_id];
  assign w_own_last  = req_last[r_grant_id];
  assign w_push      = w_busy && w_own_valid && !fifo_full;
  assign w_beat_inc  = r_beat_cnt + BEAT_W'(1);
  assign w_grant_inc = (r_grant_id == IW'(NREQ - 1)) ? '0 : r_grant_id + IW'(1);
  assign w_done      = (w_push && (w_own_last || (w_beat_inc == BEAT_W'(BURST))))
                     || !w_own_valid;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_found) w_state_nxt = GRANT;
      GRANT:   if (w_done)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_grant_id <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE) begin
        if (w_found) begin
          r_grant_id <= w_pick_idx;
          r_beat_cnt <= '0;
        end
      end else begin
        if (w_push) r_beat_cnt <= w_beat_inc;
        if (w_done) r_rr_ptr   <= w_grant_inc;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (w_push) req_ready[r_grant_id] = 1'b1;
  end

  assign push     = w_push;
  assign busy     = w_busy;
  assign grant_id = r_grant_id;
  assign data_in  = w_busy ? req_data[r_grant_id*WIDTH +: WIDTH] : '0;

`ifdef FIFO_PUSH_ARB_STATS_EN
  logic [STALL_W-1:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_busy && w_own_valid && fifo_full && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + STALL_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
